fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 99 +++++++++
 tb/tb_fetch_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a RUN/HALTED FSM.
// Handles the stall, branch redirect and HALT-opcode stop, with a global enable.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        stop,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] instruccion,
    output logic [31:0] pc_plus4,
    output logic        valid,
    output logic        halted
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    localparam logic [5:0] HALT_OPCODE = 6'b111111;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_inc;
    logic [31:0] instr_next;
    logic [31:0] pc4_next;
    logic        valid_next;

    // Plain 32-bit add: the top of the address space wraps to zero silently.
    assign pc_inc    = pc + 32'd4;
    assign imem_addr = pc;
    assign halted    = (state == HALTED);

    // NOTE: every next-value starts from a hold default, so no branch of the
    // if-chain can leave a signal unassigned and infer a latch.
    always_comb begin
        pc_next    = pc;
        instr_next = instruccion;
        pc4_next   = pc_plus4;
        valid_next = valid;
        state_next = state;

        if (branch_taken) begin
            // A redirect also cancels a HALT fetched on the wrong path.
            pc_next    = {branch_target[31:2], 2'b00};
            instr_next = NOP_WORD;
            valid_next = 1'b0;
            state_next = RUN;
        end else begin
            unique case (state)
                HALTED: begin
                    instr_next = NOP_WORD;
                    valid_next = 1'b0;
                end
                RUN: begin
                    if (!stop) begin
                        pc_next    = pc_inc;
                        instr_next = imem_data;
                        pc4_next   = pc_inc;
                        valid_next = 1'b1;
                        if (imem_data[31:26] == HALT_OPCODE) begin
                            state_next = HALTED;
                        end
                    end
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            instruccion <= NOP_WORD;
            pc_plus4    <= 32'h0000_0000;
            valid       <= 1'b0;
            state       <= RUN;
        end else if (ena) begin
            pc          <= pc_next;
            instruccion <= instr_next;
            pc_plus4    <= pc4_next;
            valid       <= valid_next;
            state       <= state_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic
// compared against a rule-level reference model of the fetch stage.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        stop;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instruccion;
    logic [31:0] pc_plus4;
    logic        valid;
    logic        halted;

    // Instruction memory: 256 words, aliased over the whole address space.
    logic [31:0] mem [256];
    assign imem_data = mem[imem_addr[9:2]];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_halted;

    fetch_stage #(.RESET_PC(RST_PC), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst(rst), .ena(ena), .stop(stop),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .instruccion(instruccion), .pc_plus4(pc_plus4),
        .valid(valid), .halted(halted)
    );

    always #5 clk = ~clk;

    // Apply the fetch rules to the model for the current inputs, then take one edge.
    task automatic step();
        logic [31:0] w;
        w = mem[m_pc[9:2]];
        if (rst) begin
            m_pc = RST_PC; m_instr = NOP; m_pc4 = 0; m_valid = 0; m_halted = 0;
        end else if (ena) begin
            if (branch_taken) begin
                m_pc = branch_target & 32'hFFFF_FFFC;
                m_instr = NOP; m_valid = 0; m_halted = 0;
            end else if (m_halted) begin
                m_instr = NOP; m_valid = 0;
            end else if (!stop) begin
                m_instr  = w;
                m_pc     = m_pc + 32'd4;
                m_pc4    = m_pc;
                m_valid  = 1;
                m_halted = (w[31:26] == 6'h3F);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; ena = 1; stop = 0; branch_taken = 0; branch_target = 0;
    endtask

    task automatic test_reset();
        rst = 1; ena = 0; stop = 1; branch_taken = 1; branch_target = 32'h0000_0ABC;
        step();
        n_tests++;
        if ({imem_addr, instruccion, pc_plus4, valid, halted} !== {RST_PC, NOP, 32'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: pc=%h instr=%h pc4=%h valid=%b halted=%b, want pc=%h instr=%h pc4=0 valid=0 halted=0",
                     imem_addr, instruccion, pc_plus4, valid, halted, RST_PC, NOP);
        end
        idle_inputs();
    endtask

    task automatic test_sequential();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
        rst = 1; step(); idle_inputs();
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (instruccion !== exp_w[i] || pc_plus4 !== 32'(4 * (i + 1)) || valid !== 1'b1) begin
                n_fail++;
                $display("FAIL seq_fetch[%0d]: instr=%h pc4=%h valid=%b, want instr=%h pc4=%h valid=1",
                         i, instruccion, pc_plus4, valid, exp_w[i], 32'(4 * (i + 1)));
            end
        end
    endtask

    task automatic test_stall();
        rst = 1; step(); idle_inputs();
        step(); step();
        n_tests++;
        if (imem_addr !== 32'h8) begin
            n_fail++;
            $display("FAIL stall_setup: pc=%h, want 00000008", imem_addr);
        end
        stop = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if ({imem_addr, instruccion, pc_plus4, valid} !== {32'h8, 32'h22, 32'h8, 1'b1}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: pc=%h instr=%h pc4=%h valid=%b, want pc=8 instr=22 pc4=8 valid=1",
                         i, imem_addr, instruccion, pc_plus4, valid);
            end
        end
        stop = 0;
        step();
        n_tests++;
        if ({imem_addr, instruccion, pc_plus4, valid} !== {32'hC, 32'h33, 32'hC, 1'b1}) begin
            n_fail++;
            $display("FAIL stall_resume: pc=%h instr=%h pc4=%h valid=%b, want pc=c instr=33 pc4=c valid=1",
                     imem_addr, instruccion, pc_plus4, valid);
        end
    endtask

    task automatic test_branch();
        branch_taken = 1; stop = 1; branch_target = 32'h0000_0043;
        step();
        n_tests++;
        if ({imem_addr, instruccion, pc_plus4, valid} !== {32'h40, NOP, 32'hC, 1'b0}) begin
            n_fail++;
            $display("FAIL branch: pc=%h instr=%h pc4=%h valid=%b, want pc=40 instr=%h pc4=c valid=0",
                     imem_addr, instruccion, pc_plus4, valid, NOP);
        end
        idle_inputs();
    endtask

    task automatic test_halt();
        mem[16] = 32'hFC00_0000;
        step();
        n_tests++;
        if ({instruccion, valid, halted, imem_addr} !== {32'hFC00_0000, 1'b1, 1'b1, 32'h44}) begin
            n_fail++;
            $display("FAIL halt_fetch: instr=%h valid=%b halted=%b pc=%h, want instr=fc000000 valid=1 halted=1 pc=44",
                     instruccion, valid, halted, imem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            stop = 1'($urandom_range(0, 1));
            step();
            n_tests++;
            if ({imem_addr, instruccion, valid, halted} !== {32'h44, NOP, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL halt_frozen[%0d]: pc=%h instr=%h valid=%b halted=%b, want pc=44 instr=%h valid=0 halted=1",
                         i, imem_addr, instruccion, valid, halted, NOP);
            end
        end
        stop = 0; branch_taken = 1; branch_target = 32'h100;
        step();
        n_tests++;
        if ({imem_addr, halted, valid} !== {32'h100, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL halt_exit: pc=%h halted=%b valid=%b, want pc=100 halted=0 valid=0",
                     imem_addr, halted, valid);
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        mem[255] = 32'h0123_4567;
        branch_taken = 1; branch_target = 32'hFFFF_FFFC;
        step();
        idle_inputs();
        step();
        n_tests++;
        if ({imem_addr, pc_plus4, instruccion, valid} !== {32'h0, 32'h0, 32'h0123_4567, 1'b1}) begin
            n_fail++;
            $display("FAIL pc_wrap: pc=%h pc4=%h instr=%h valid=%b, want pc=0 pc4=0 instr=01234567 valid=1",
                     imem_addr, pc_plus4, instruccion, valid);
        end
    endtask

    task automatic test_enable();
        logic [31:0] s_pc, s_instr, s_pc4;
        logic        s_valid, s_halted;
        branch_taken = 1; branch_target = 32'h200;
        step();
        idle_inputs();
        step(); step();
        s_pc = 32'h208; s_instr = mem[129]; s_pc4 = 32'h208; s_valid = 1; s_halted = 0;
        ena = 0;
        for (int i = 0; i < 3; i++) begin
            branch_taken  = (i == 1);
            branch_target = $urandom();
            stop          = 1'($urandom_range(0, 1));
            step();
            n_tests++;
            if ({imem_addr, instruccion, pc_plus4, valid, halted} !== {s_pc, s_instr, s_pc4, s_valid, s_halted}) begin
                n_fail++;
                $display("FAIL ena_hold[%0d]: pc=%h instr=%h pc4=%h valid=%b halted=%b, want pc=%h instr=%h pc4=%h valid=%b halted=%b",
                         i, imem_addr, instruccion, pc_plus4, valid, halted, s_pc, s_instr, s_pc4, s_valid, s_halted);
            end
        end
        branch_taken = 0; rst = 1;
        step();
        n_tests++;
        if ({imem_addr, instruccion, pc_plus4, valid} !== {RST_PC, NOP, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL ena_reset: pc=%h instr=%h pc4=%h valid=%b, want pc=%h instr=%h pc4=0 valid=0",
                     imem_addr, instruccion, pc_plus4, valid, RST_PC, NOP);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0)
                mem[$urandom_range(0, 255)] = {6'h3F, 26'($urandom())};
            rst           = ($urandom_range(0, 39) == 0);
            ena           = ($urandom_range(0, 5) != 0);
            stop          = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 7) == 0);
            branch_target = $urandom();
            step();
            n_tests++;
            if ({imem_addr, instruccion, pc_plus4, valid, halted} !== {m_pc, m_instr, m_pc4, m_valid, m_halted}) begin
                n_fail++;
                $display("FAIL random[%0d]: pc=%h instr=%h pc4=%h valid=%b halted=%b, want pc=%h instr=%h pc4=%h valid=%b halted=%b",
                         i, imem_addr, instruccion, pc_plus4, valid, halted, m_pc, m_instr, m_pc4, m_valid, m_halted);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom() & 32'hF7FF_FFFF;
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halted = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_halt();
        test_wrap();
        test_enable();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
